// File: rtl/apb_exe_master_pkg.sv
// Shared types and sizing helpers for the APB execution-unit requester.
package apb_master_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, GAP, DONE} state_t;

  typedef enum logic [1:0] {CMD_WRITE, CMD_READ, CMD_EXEC, CMD_RSVD} cmd_t;

  // Width of a down-counter that must hold any load value below max(a, b).
  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/apb_exe_master_if.sv
// APB bus bundle between the requester and the apb_exe_unit responders.
interface apb_exe_master_if #(
  parameter int SEL_WIDTH  = 3,
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 32
);
  logic [SEL_WIDTH-1:0]  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  PREADY;
  logic                  PSLVERR;
  logic [DATA_WIDTH-1:0] PRDATA;

  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                  input  PREADY, PSLVERR, PRDATA);
  modport slave  (input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                  output PREADY, PSLVERR, PRDATA);
endinterface

// File: rtl/apb_exe_master_wait_timer.sv
// Loadable down-counter shared by the EXEC gap and the ACCESS timeout.
module apb_wait_timer #(
  parameter int CNT_W = 5
) (
  input  logic             i_PCLK,
  input  logic             i_PRESETn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expired
);
  logic [CNT_W-1:0] count;

  always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
    if (!i_PRESETn)              count <= '0;
    else if (load)               count <= load_val;
    else if (en && count != '0)  count <= count - 1'b1;
  end

  assign expired = (count == '0);
endmodule

// File: rtl/apb_exe_master.sv
// APB requester: runs WRITE / READ / EXEC commands against one responder.
module apb_exe_master
  import apb_master_pkg::*;
#(
  parameter int SEL_WIDTH  = 3,
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 32,
  parameter int EXEC_GAP   = 2,
  parameter int TIMEOUT    = 16,
  localparam int SEL_IDX_W = (SEL_WIDTH > 1) ? $clog2(SEL_WIDTH) : 1
) (
  input  logic                  i_PCLK,
  input  logic                  i_PRESETn,
  input  logic                  i_start,
  input  logic [1:0]            i_cmd,
  input  logic [SEL_IDX_W-1:0]  i_sel,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic                  o_timeout,
  output logic [DATA_WIDTH-1:0] o_rdata,
  apb_exe_master_if.master      bus
);
  localparam int CNT_W = cnt_width(TIMEOUT, EXEC_GAP);

  state_t               state;
  cmd_t                 cmd_q;
  logic [SEL_IDX_W-1:0] sel_q;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_en;
  logic             tmr_expired;

  logic exec_wr_ok;
  assign exec_wr_ok = bus.PREADY && bus.PWRITE && (cmd_q == CMD_EXEC) && !bus.PSLVERR;

  // SETUP arms the timeout; a clean EXEC write re-arms the same counter for the gap.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_en   = 1'b0;
    case (state)
      SETUP: begin
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(TIMEOUT - 1);
      end
      ACCESS: begin
        tmr_en = 1'b1;
        if (exec_wr_ok && EXEC_GAP != 0) begin
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(EXEC_GAP - 1);
        end
      end
      GAP:     tmr_en = 1'b1;
      default: ;
    endcase
  end

  apb_wait_timer #(.CNT_W(CNT_W)) u_timer (
    .i_PCLK   (i_PCLK),
    .i_PRESETn(i_PRESETn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .expired  (tmr_expired)
  );

  always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
    if (!i_PRESETn) begin
      state       <= IDLE;
      cmd_q       <= CMD_WRITE;
      sel_q       <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_timeout   <= 1'b0;
      o_rdata     <= '0;
      bus.PSEL    <= '0;
      bus.PENABLE <= 1'b0;
      bus.PWRITE  <= 1'b0;
      bus.PADDR   <= '0;
      bus.PWDATA  <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: if (i_start) begin
          o_busy <= 1'b1;
          if (i_cmd == CMD_RSVD || int'(i_sel) >= SEL_WIDTH) begin
            state     <= DONE;
            o_done    <= 1'b1;
            o_err     <= 1'b1;
            o_timeout <= 1'b0;
          end else begin
            state      <= SETUP;
            cmd_q      <= cmd_t'(i_cmd);
            sel_q      <= i_sel;
            bus.PSEL   <= SEL_WIDTH'(1) << i_sel;
            bus.PWRITE <= (i_cmd != CMD_READ);
            bus.PADDR  <= i_addr;
            bus.PWDATA <= i_wdata;
          end
        end
        SETUP: begin
          state       <= ACCESS;
          bus.PENABLE <= 1'b1;
        end
        ACCESS: begin
          if (bus.PREADY) begin
            bus.PENABLE <= 1'b0;
            if (exec_wr_ok) begin
              bus.PWRITE <= 1'b0;
              if (EXEC_GAP == 0) begin
                state <= SETUP;
              end else begin
                state    <= GAP;
                bus.PSEL <= '0;
              end
            end else begin
              state     <= DONE;
              bus.PSEL  <= '0;
              o_done    <= 1'b1;
              o_err     <= bus.PSLVERR;
              o_timeout <= 1'b0;
              if (!bus.PWRITE) o_rdata <= bus.PRDATA;
            end
          end else if (tmr_expired) begin
            state       <= DONE;
            bus.PSEL    <= '0;
            bus.PENABLE <= 1'b0;
            o_done      <= 1'b1;
            o_err       <= 1'b1;
            o_timeout   <= 1'b1;
            o_rdata     <= '0;
          end
        end
        GAP: if (tmr_expired) begin
          state    <= SETUP;
          bus.PSEL <= SEL_WIDTH'(1) << sel_q;
        end
        DONE: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
